// File: rtl/i2c_scl_responder.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_scl_responder
//  Purpose  : I2C target-side SCL front end. It synchronizes and
//             glitch-filters SCL/SDA, reports SCL edges and START/STOP
//             conditions, tracks bus-busy, and measures the SCL rise-to-rise
//             period. It also stretches SCL (open-drain low) on backend
//             request, with a timeout.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_sys_clk       system clock (only clock)
//    i_rst_n         asynchronous active-low reset
//    i_enable        block enable (sync/filter keep running when low)
//    i_scl_in        SCL pad input, asynchronous
//    i_sda_in        SDA pad input, asynchronous
//    i_hold_req      backend request to hold SCL low
//    o_scl_oe        1 = drive SCL pad low
//    o_scl_rise      pulse on filtered SCL rise
//    o_scl_fall      pulse on filtered SCL fall
//    o_start         pulse on START / repeated START
//    o_stop          pulse on STOP
//    o_bus_busy      high between START and STOP
//    o_stretching    high while the stretch FSM is in STRETCH
//    o_period[15:0]  last measured SCL rise-to-rise period (cycles)
//    o_period_valid  pulse when o_period updates
//    o_timeout       pulse when a stretch is forcibly ended
// ============================================================================
module i2c_scl_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter int          FILTER_LEN  = 3,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic        i_sys_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_scl_in,
  input  logic        i_sda_in,
  input  logic        i_hold_req,
  output logic        o_scl_oe,
  output logic        o_scl_rise,
  output logic        o_scl_fall,
  output logic        o_start,
  output logic        o_stop,
  output logic        o_bus_busy,
  output logic        o_stretching,
  output logic [15:0] o_period,
  output logic        o_period_valid,
  output logic        o_timeout
);

  localparam logic [3:0] C_FILTER_LEN = 4'(FILTER_LEN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_STRETCH = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Line index 0 = SCL, 1 = SDA.
  logic [1:0]             w_pad;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] sync_d [2];
  logic [3:0]             fcnt_q [2];
  logic [3:0]             fcnt_d [2];
  logic [1:0]             filt_q, filt_d;
  logic [1:0]             filt_prev_q, filt_prev_d;

  logic        scl_rise_q, scl_rise_d;
  logic        scl_fall_q, scl_fall_d;
  logic        start_q, start_d;
  logic        stop_q, stop_d;
  logic        bus_busy_q, bus_busy_d;
  logic [15:0] per_cnt_q, per_cnt_d;
  logic [15:0] period_q, period_d;
  logic        period_valid_q, period_valid_d;
  logic        first_q, first_d;
  logic        w_scl_hi_both;
  logic [15:0] w_per_inc;

  state_e      state_q, state_d;
  logic [15:0] stretch_cnt_q, stretch_cnt_d;
  logic        w_timeout;

  assign w_pad = {i_sda_in, i_scl_in};

  // Synchronizer, glitch filter, edge/condition detection, period counter.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], w_pad[i]};
      filt_d[i] = filt_q[i];
      fcnt_d[i] = 4'd0;
      // Count consecutive disagreeing samples; any agreeing sample clears.
      if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
        if (fcnt_q[i] + 4'd1 == C_FILTER_LEN) begin
          filt_d[i] = sync_q[i][SYNC_STAGES-1];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 4'd1;
        end
      end
    end
    filt_prev_d = filt_q;

    // SCL high now and last cycle: excludes a simultaneous SCL/SDA change.
    w_scl_hi_both = filt_q[0] & filt_prev_q[0];
    scl_rise_d    = i_enable & filt_q[0] & ~filt_prev_q[0];
    scl_fall_d    = i_enable & ~filt_q[0] & filt_prev_q[0];
    start_d       = i_enable & w_scl_hi_both & ~filt_q[1] & filt_prev_q[1];
    stop_d        = i_enable & w_scl_hi_both & filt_q[1] & ~filt_prev_q[1];

    bus_busy_d = bus_busy_q;
    if (start_q) bus_busy_d = 1'b1;
    if (stop_q)  bus_busy_d = 1'b0;
    if (!i_enable) bus_busy_d = 1'b0;

    w_per_inc      = (per_cnt_q == 16'hFFFF) ? 16'hFFFF : per_cnt_q + 16'd1;
    per_cnt_d      = w_per_inc;
    period_d       = period_q;
    period_valid_d = 1'b0;
    first_d        = first_q;
    if (scl_rise_q) begin
      per_cnt_d = 16'd0;
      // The first rise only starts a measurement window.
      if (first_q) begin
        first_d = 1'b0;
      end else begin
        period_d       = w_per_inc;
        period_valid_d = 1'b1;
      end
    end
    if (start_q) first_d = 1'b1;
    if (!i_enable) begin
      per_cnt_d      = 16'd0;
      period_valid_d = 1'b0;
      first_d        = 1'b1;
    end
  end

  // Stretch FSM.
  always_comb begin
    state_d       = state_q;
    stretch_cnt_d = stretch_cnt_q;
    w_timeout     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (scl_fall_q && i_hold_req) begin
          state_d       = ST_STRETCH;
          stretch_cnt_d = 16'd0;
        end else if (i_hold_req && filt_q[0]) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (scl_fall_q && i_hold_req) begin
          state_d       = ST_STRETCH;
          stretch_cnt_d = 16'd0;
        end else if (!i_hold_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_STRETCH: begin
        if (!i_hold_req) begin
          state_d = ST_RELEASE;
        end else if (stretch_cnt_q == TIMEOUT_CYC) begin
          state_d   = ST_RELEASE;
          w_timeout = 1'b1;
        end else begin
          stretch_cnt_d = stretch_cnt_q + 16'd1;
        end
      end
      ST_RELEASE: begin
        // Backend request is ignored until the master raises SCL again.
        if (scl_rise_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (stop_q || !i_enable) begin
      state_d   = ST_IDLE;
      w_timeout = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '1;
        fcnt_q[i] <= 4'd0;
      end
      filt_q         <= 2'b11;
      filt_prev_q    <= 2'b11;
      scl_rise_q     <= 1'b0;
      scl_fall_q     <= 1'b0;
      start_q        <= 1'b0;
      stop_q         <= 1'b0;
      bus_busy_q     <= 1'b0;
      per_cnt_q      <= 16'd0;
      period_q       <= 16'd0;
      period_valid_q <= 1'b0;
      first_q        <= 1'b1;
      state_q        <= ST_IDLE;
      stretch_cnt_q  <= 16'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= sync_d[i];
        fcnt_q[i] <= fcnt_d[i];
      end
      filt_q         <= filt_d;
      filt_prev_q    <= filt_prev_d;
      scl_rise_q     <= scl_rise_d;
      scl_fall_q     <= scl_fall_d;
      start_q        <= start_d;
      stop_q         <= stop_d;
      bus_busy_q     <= bus_busy_d;
      per_cnt_q      <= per_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      first_q        <= first_d;
      state_q        <= state_d;
      stretch_cnt_q  <= stretch_cnt_d;
    end
  end

  assign o_scl_oe       = (state_q == ST_STRETCH);
  assign o_stretching   = (state_q == ST_STRETCH);
  assign o_scl_rise     = scl_rise_q;
  assign o_scl_fall     = scl_fall_q;
  assign o_start        = start_q;
  assign o_stop         = stop_q;
  assign o_bus_busy     = bus_busy_q;
  assign o_period       = period_q;
  assign o_period_valid = period_valid_q;
  assign o_timeout      = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_i2c_scl_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_scl_responder
//  Purpose  : Directed self-checking bench for i2c_scl_responder. Stimulus
//             tasks queue the expected pulses; a negedge monitor matches
//             every DUT pulse against the queue.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_scl_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        scl = 1'b1;
  logic        sda = 1'b1;
  logic        hold = 1'b0;
  logic        o_scl_oe, o_scl_rise, o_scl_fall, o_start, o_stop;
  logic        o_bus_busy, o_stretching, o_period_valid, o_timeout;
  logic [15:0] o_period;

  i2c_scl_responder #(
    .SYNC_STAGES(2),
    .FILTER_LEN (3),
    .TIMEOUT_CYC(16'd40)
  ) dut (
    .i_sys_clk     (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_scl_in      (scl),
    .i_sda_in      (sda),
    .i_hold_req    (hold),
    .o_scl_oe      (o_scl_oe),
    .o_scl_rise    (o_scl_rise),
    .o_scl_fall    (o_scl_fall),
    .o_start       (o_start),
    .o_stop        (o_stop),
    .o_bus_busy    (o_bus_busy),
    .o_stretching  (o_stretching),
    .o_period      (o_period),
    .o_period_valid(o_period_valid),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected pulse kinds: 0 start, 1 stop, 2 scl_rise, 3 scl_fall,
  // 4 period_valid (data = period), 5 timeout.
  typedef struct {
    int kind;
    int cyc;
    int data;
  } ev_t;
  ev_t exp_q[$];

  // Bench model of the period measurement bookkeeping.
  bit m_first = 1'b1;
  bit m_en = 1'b1;
  int m_last_rise = 0;

  function automatic string kname(input int k);
    case (k)
      0: return "start";
      1: return "stop";
      2: return "scl_rise";
      3: return "scl_fall";
      4: return "period_valid";
      default: return "timeout";
    endcase
  endfunction

  task automatic push(input int k, input int c, input int d);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: match observed pulses and flag expectations that went by.
  always @(negedge clk) begin
    logic [5:0] seen;
    int idx;
    seen = {o_timeout, o_period_valid, o_scl_fall, o_scl_rise, o_stop, o_start};
    for (int k = 0; k < 6; k++) begin
      if (seen[k]) begin
        idx = -1;
        foreach (exp_q[j]) begin
          if (idx < 0 && exp_q[j].kind == k && exp_q[j].cyc == cyc) idx = j;
        end
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL %s: unexpected pulse at cycle %0d (none expected)", kname(k), cyc);
        end else begin
          if (k == 4 && int'(o_period) != exp_q[idx].data) begin
            errors++;
            $display("FAIL period: got %0d expected %0d at cycle %0d",
                     o_period, exp_q[idx].data, cyc);
          end
          exp_q.delete(idx);
        end
      end
    end
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      if (exp_q[j].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: no pulse, expected at cycle %0d", kname(exp_q[j].kind), exp_q[j].cyc);
        exp_q.delete(j);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic at_neg(input int c);
    tick_to(c);
    @(negedge clk);
  endtask

  // Pad changes appear as pulses 6 cycles later; period valid one after rise.
  task automatic drive_scl(input logic v);
    int p;
    p = cyc;
    if (v !== scl && m_en) begin
      if (v) begin
        push(2, p + 6, 0);
        if (!m_first) push(4, p + 7, p + 6 - m_last_rise);
        m_first     = 1'b0;
        m_last_rise = p + 6;
      end else begin
        push(3, p + 6, 0);
      end
    end
    scl = v;
  endtask

  task automatic drive_sda(input logic v);
    int p;
    p = cyc;
    if (v !== sda && m_en && scl === 1'b1) begin
      if (v) begin
        push(1, p + 6, 0);
      end else begin
        push(0, p + 6, 0);
        m_first = 1'b1;
      end
    end
    sda = v;
  endtask

  // Simultaneous change: only the SCL edge is expected.
  task automatic drive_both(input logic v_scl, input logic v_sda);
    drive_scl(v_scl);
    sda = v_sda;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p, t0, s, r, f;
    bit seen_low;

    // ---- Reset state ----
    tick(3);
    at_neg(cyc);
    chk("reset o_scl_oe", o_scl_oe, 0);
    chk("reset o_bus_busy", o_bus_busy, 0);
    chk("reset o_period", o_period, 0);
    chk("reset pulses", {o_scl_rise, o_scl_fall, o_start, o_stop, o_period_valid, o_timeout, o_stretching}, 0);
    chk("reset filtered lines", dut.filt_q, 3);
    tick(1);
    rst_n = 1'b1;
    tick(5);

    // ---- START then STOP ----
    p = cyc;
    drive_sda(1'b0);
    at_neg(p + 5);  chk("busy before start", o_bus_busy, 0);
    at_neg(p + 7);  chk("busy after start", o_bus_busy, 1);
    tick_to(p + 20);
    drive_sda(1'b1);
    at_neg(p + 26); chk("busy at stop", o_bus_busy, 1);
    at_neg(p + 27); chk("busy after stop", o_bus_busy, 0);

    // ---- 2-cycle SCL glitch is filtered ----
    tick(3);
    scl = 1'b0;
    tick(2);
    scl = 1'b1;
    seen_low = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (dut.filt_q[0] !== 1'b1) seen_low = 1'b1;
    end
    chk("glitch filtered scl low", int'(seen_low), 0);

    // ---- START, 100-cycle SCL, simultaneous change, STOP ----
    tick(3);
    p = cyc;
    drive_sda(1'b0);
    t0 = p + 12;
    tick_to(t0);
    drive_both(1'b0, 1'b1);
    at_neg(t0 + 10); chk("busy after simultaneous change", o_bus_busy, 1);
    tick_to(t0 + 50);  drive_scl(1'b1);
    tick_to(t0 + 100); drive_scl(1'b0);
    tick_to(t0 + 120); drive_sda(1'b0);
    tick_to(t0 + 150); drive_scl(1'b1);
    tick_to(t0 + 200); drive_scl(1'b0);
    tick_to(t0 + 250); drive_scl(1'b1);
    at_neg(t0 + 260); chk("period after toggling", o_period, 100);
    tick_to(t0 + 270); drive_sda(1'b1);
    at_neg(t0 + 280); chk("busy after second stop", o_bus_busy, 0);

    // ---- Disable: busy cleared, pulses suppressed, period held ----
    tick(3);
    p = cyc;
    drive_sda(1'b0);
    at_neg(p + 10); chk("busy before disable", o_bus_busy, 1);
    tick_to(p + 12);
    enable = 1'b0;
    m_en   = 1'b0;
    at_neg(p + 13);
    chk("busy when disabled", o_bus_busy, 0);
    chk("period held when disabled", o_period, 100);
    tick_to(p + 15); drive_scl(1'b0);
    tick_to(p + 30); drive_scl(1'b1);
    tick_to(p + 40); drive_sda(1'b1);
    at_neg(p + 50); chk("busy still 0 when disabled", o_bus_busy, 0);
    tick(1);
    enable  = 1'b1;
    m_en    = 1'b1;
    m_first = 1'b1;

    // ---- Stretch with hold_req, RELEASE, then timeout ----
    tick(3);
    p = cyc;
    hold = 1'b1;
    at_neg(p + 4);
    chk("no stretch while scl high", o_scl_oe, 0);
    chk("state armed", int'(dut.state_q), 1);
    tick_to(p + 6);
    s = cyc;
    drive_scl(1'b0);
    at_neg(s + 6); chk("oe during fall pulse", o_scl_oe, 0);
    at_neg(s + 7);
    chk("oe after fall", o_scl_oe, 1);
    chk("stretching after fall", o_stretching, 1);
    tick_to(s + 20);
    hold = 1'b0;
    at_neg(s + 20); chk("oe while hold dropped", o_scl_oe, 1);
    at_neg(s + 21);
    chk("oe after hold drop", o_scl_oe, 0);
    chk("state release", int'(dut.state_q), 3);
    tick_to(s + 23);
    hold = 1'b1;
    at_neg(s + 30);
    chk("hold ignored in release", o_scl_oe, 0);
    chk("state stays release", int'(dut.state_q), 3);
    tick_to(s + 40);
    r = cyc;
    drive_scl(1'b1);
    at_neg(r + 9); chk("state armed after rise", int'(dut.state_q), 1);
    tick_to(r + 12);
    f = cyc;
    drive_scl(1'b0);
    push(5, f + 47, 0);
    at_neg(f + 46); chk("oe before timeout", o_scl_oe, 1);
    at_neg(f + 47); chk("oe at timeout", o_scl_oe, 1);
    at_neg(f + 48);
    chk("oe after timeout", o_scl_oe, 0);
    chk("state release after timeout", int'(dut.state_q), 3);
    hold = 1'b0;
    tick_to(f + 55);
    drive_scl(1'b1);
    tick(12);

    // ---- STOP mid-stretch ----
    p = cyc;
    drive_sda(1'b0);
    tick_to(p + 10);
    hold = 1'b1;
    tick_to(p + 12);
    f = cyc;
    drive_scl(1'b0);
    at_neg(f + 8); chk("oe stretching before stop", o_scl_oe, 1);
    tick_to(f + 10);
    drive_scl(1'b1);
    at_neg(f + 18); chk("oe kept after scl rise", o_scl_oe, 1);
    tick_to(f + 20);
    drive_sda(1'b1);
    at_neg(f + 26); chk("oe at stop pulse", o_scl_oe, 1);
    at_neg(f + 27);
    chk("oe after stop", o_scl_oe, 0);
    chk("state idle after stop", int'(dut.state_q), 0);
    hold = 1'b0;
    tick(5);

    // ---- Reset mid-stretch ----
    hold = 1'b1;
    tick(3);
    f = cyc;
    drive_scl(1'b0);
    at_neg(f + 10); chk("oe before reset", o_scl_oe, 1);
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("oe async reset", o_scl_oe, 0);
    chk("state idle in reset", int'(dut.state_q), 0);
    hold    = 1'b0;
    scl     = 1'b1;
    m_first = 1'b1;
    tick(4);
    chk("period in reset", o_period, 0);
    rst_n = 1'b1;
    tick(12);

    foreach (exp_q[j]) begin
      checks++;
      errors++;
      $display("FAIL %s: no pulse, expected at cycle %0d", kname(exp_q[j].kind), exp_q[j].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
